conv_result_streamer: RTL and testbench

Output-side companion of the 1-D convolution engine. Captures the engine's 30-entry signed 18-bit result array when its done pulse fires, then streams the entries one per beat over a valid/ready interface. Each streamed entry is arithmetic-shifted, optionally ReLU-clipped and saturated to OUT_W bits. It sits between the convolution engine and the downstream activation buffer / next layer.

---
 rtl/conv_result_streamer.sv | 141 ++++++++++++++
 tb/tb_conv_result_streamer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_streamer.sv
// conv_result_streamer: captures the conv engine's result array on done_in and
// streams it one entry per beat (shift, optional ReLU, saturate to OUT_W bits).
// Latency: done_in at edge k -> beat 0 valid from edge k+1; outputs registered.
// Backpressure: m_data/m_index/m_last hold while m_valid && !m_ready.
// Ports: clk/rst (sync, active-high); done_in + result_in (flattened array, entry i
//   at [i*IN_W +: IN_W]); m_valid/m_ready/m_data/m_index/m_last stream;
//   busy, frame_done, overrun (sticky, cleared by clr_overrun; set wins).
module conv_result_streamer #(
  parameter int N_RESULTS = 30,
  parameter int IN_W      = 18,
  parameter int OUT_W     = 8,
  parameter int SHIFT     = 0,
  parameter bit RELU      = 1'b1,
  localparam int IDX_W    = $clog2(N_RESULTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      done_in,
  input  logic [N_RESULTS*IN_W-1:0] result_in,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [OUT_W-1:0]          m_data,
  output logic [IDX_W-1:0]          m_index,
  output logic                      m_last,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overrun,
  input  logic                      clr_overrun
);

  typedef enum logic [1:0] {IDLE, STREAM, FIN} state_t;

  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(N_RESULTS - 1);
  localparam logic signed [IN_W-1:0] U_MAX    = IN_W'(2**OUT_W - 1);
  localparam logic signed [IN_W-1:0] S_MAX    = IN_W'(2**(OUT_W-1) - 1);
  localparam logic signed [IN_W-1:0] S_MIN    = IN_W'(-(2**(OUT_W-1)));

  // Arithmetic shift, then either ReLU + unsigned clip or signed saturation.
  function automatic logic [OUT_W-1:0] proc(input logic signed [IN_W-1:0] x);
    logic signed [IN_W-1:0] s;
    logic [OUT_W-1:0]       r;
    s = x >>> SHIFT;
    if (RELU) begin
      if (s[IN_W-1])      r = '0;
      else if (s > U_MAX) r = '1;
      else                r = s[OUT_W-1:0];
    end else begin
      if (s > S_MAX)      r = S_MAX[OUT_W-1:0];
      else if (s < S_MIN) r = S_MIN[OUT_W-1:0];
      else                r = s[OUT_W-1:0];
    end
    return r;
  endfunction

  logic [IN_W-1:0]  res_buf_q [N_RESULTS];
  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             valid_q;
  logic [OUT_W-1:0] data_q;
  logic             last_q;
  logic             busy_q;
  logic             fd_q;
  logic             ovr_q;

  assign idx_d = idx_q + 1'b1;

  // Frame buffer: written only on an accepted done_in, never reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && done_in) begin
      for (int i = 0; i < N_RESULTS; i++) begin
        res_buf_q[i] <= result_in[i*IN_W +: IN_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      // A done_in outside IDLE is dropped; flag it, and let it beat a clear.
      if (done_in && state_q != IDLE) ovr_q <= 1'b1;
      else if (clr_overrun)           ovr_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (done_in) begin
            state_q <= STREAM;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            idx_q   <= '0;
            // Beat 0 comes straight from the input so it is valid next cycle.
            data_q  <= proc(result_in[IN_W-1:0]);
            last_q  <= 1'b0;
          end
        end
        STREAM: begin
          // valid_q is always high in STREAM, so m_ready alone marks a transfer.
          if (m_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q <= FIN;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              fd_q    <= 1'b1;
            end else begin
              idx_q  <= idx_d;
              data_q <= proc(res_buf_q[idx_d]);
              last_q <= (idx_d == LAST_IDX);
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign m_valid    = valid_q;
  assign m_data     = data_q;
  assign m_index    = idx_q;
  assign m_last     = last_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_conv_result_streamer.sv
module tb_conv_result_streamer;
  localparam int N  = 30;
  localparam int IW = 18;

  logic          clk = 1'b0;
  logic          rst, done_in, m_ready, clr_overrun;
  logic [N*IW-1:0] result_in;

  // a: SHIFT=0 RELU=1, b: SHIFT=0 RELU=0, c: SHIFT=1 RELU=1
  logic       va, vb, vc, la, lb, lc, ba, bb, bc, fa, fb, fc, oa, ob, oc;
  logic [7:0] da, db, dc;
  logic [4:0] ia, ib, ic;

  always #5 clk = ~clk;

  conv_result_streamer #(.N_RESULTS(N), .IN_W(IW), .OUT_W(8), .SHIFT(0), .RELU(1'b1)) dut_a (
    .clk(clk), .rst(rst), .done_in(done_in), .result_in(result_in),
    .m_valid(va), .m_ready(m_ready), .m_data(da), .m_index(ia), .m_last(la),
    .busy(ba), .frame_done(fa), .overrun(oa), .clr_overrun(clr_overrun));
  conv_result_streamer #(.N_RESULTS(N), .IN_W(IW), .OUT_W(8), .SHIFT(0), .RELU(1'b0)) dut_b (
    .clk(clk), .rst(rst), .done_in(done_in), .result_in(result_in),
    .m_valid(vb), .m_ready(m_ready), .m_data(db), .m_index(ib), .m_last(lb),
    .busy(bb), .frame_done(fb), .overrun(ob), .clr_overrun(clr_overrun));
  conv_result_streamer #(.N_RESULTS(N), .IN_W(IW), .OUT_W(8), .SHIFT(1), .RELU(1'b1)) dut_c (
    .clk(clk), .rst(rst), .done_in(done_in), .result_in(result_in),
    .m_valid(vc), .m_ready(m_ready), .m_data(dc), .m_index(ic), .m_last(lc),
    .busy(bc), .frame_done(fc), .overrun(oc), .clr_overrun(clr_overrun));

  typedef struct {int ea; int eb; int ec; int idx; bit last;} beat_t;
  typedef struct {int in_v; int e_r1s0; int e_r0s0; int e_r1s1;} vec_t;

  beat_t sbq[$];
  beat_t e;
  int    tests = 0;
  int    fails = 0;
  bit    hold_chk = 1'b0;
  logic [39:0] hold_val;

  function automatic int model(input int x, input int shift, input bit relu);
    int s;
    s = x >>> shift;
    if (relu) begin
      if (s < 0) return 0;
      if (s > 255) return 255;
      return s;
    end
    if (s < -128) return -128;
    if (s > 127) return 127;
    return s;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic drive_frame(input int v[N]);
    for (int i = 0; i < N; i++) result_in[i*IW +: IW] = IW'(v[i]);
    done_in = 1'b1;
    tick;
    done_in = 1'b0;
  endtask

  task automatic push_model(input int v[N]);
    for (int i = 0; i < N; i++)
      sbq.push_back('{model(v[i], 0, 1'b1), model(v[i], 0, 1'b0), model(v[i], 1, 1'b1), i, (i == N-1)});
  endtask

  // mode 0: ready held high; mode 1: pattern 1,0,0,1 with random extra stalls
  task automatic drain(input int mode, input int maxc);
    int c;
    c = 0;
    while (sbq.size() != 0 && c < maxc) begin
      if (mode == 0) m_ready = 1'b1;
      else m_ready = ((c % 4 == 0) || (c % 4 == 3)) && ($urandom_range(0, 3) != 0);
      tick;
      c++;
    end
    m_ready = 1'b1;
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d beats outstanding after %0d cycles, required 0", sbq.size(), maxc);
      sbq.delete();
    end
  endtask

  task automatic run_until(input int remaining, input int maxc);
    int c;
    c = 0;
    m_ready = 1'b1;
    while (sbq.size() > remaining && c < maxc) begin
      tick;
      c++;
    end
    chk("run_until_remaining", sbq.size(), remaining);
  endtask

  // Scoreboard and stall-hold monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk && va) begin
        tests++;
        if ({da, db, dc, ia, ib, ic, la} !== hold_val) begin
          fails++;
          $display("FAIL stall_hold: got %h, required %h", {da, db, dc, ia, ib, ic, la}, hold_val);
        end
      end
      hold_chk = va && !m_ready;
      hold_val = {da, db, dc, ia, ib, ic, la};
      if (va && m_ready) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL beat_unexpected: got index %0d, required no beat", ia);
        end else begin
          e = sbq.pop_front();
          if ({vb, vc} !== 2'b11 || da !== e.ea[7:0] || db !== e.eb[7:0] || dc !== e.ec[7:0] ||
              int'(ia) != e.idx || int'(ib) != e.idx || int'(ic) != e.idx ||
              la !== e.last || lb !== e.last || lc !== e.last) begin
            fails++;
            $display("FAIL beat idx %0d: got data %h/%h/%h index %0d last %b, required %h/%h/%h index %0d last %b",
                     e.idx, da, db, dc, ia, la, e.ea[7:0], e.eb[7:0], e.ec[7:0], e.idx, e.last);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    int   v[N];

    tbl[0] = '{301, 255, 127, 150};
    tbl[1] = '{-3, 0, -3, 0};
    tbl[2] = '{511, 255, 127, 255};
    tbl[3] = '{509, 255, 127, 254};
    tbl[4] = '{-200, 0, -128, 0};
    tbl[5] = '{255, 255, 127, 127};
    tbl[6] = '{256, 255, 127, 128};
    tbl[7] = '{-128, 0, -128, 0};
    tbl[8] = '{127, 127, 127, 63};
    tbl[9] = '{-129, 0, -128, 0};

    rst = 1'b1; done_in = 1'b0; m_ready = 1'b0; clr_overrun = 1'b0; result_in = '0;
    tick; tick;
    rst = 1'b0;
    tick;
    chk("rst_valid", {va, vb, vc}, 0);
    chk("rst_data", {da, db, dc}, 0);
    chk("rst_index_last", {ia, la}, 0);
    chk("rst_busy_fd_ovr", {ba, fa, oa}, 0);

    // Frame A: ramp i*10-50, ready held high
    for (int i = 0; i < N; i++) v[i] = i*10 - 50;
    push_model(v);
    m_ready = 1'b1;
    drive_frame(v);
    chk("capture_valid", va, 1);
    chk("capture_index", ia, 0);
    chk("capture_busy", ba, 1);
    drain(0, 100);
    chk("fin_frame_done", fa, 1);
    chk("fin_busy", ba, 1);
    chk("fin_valid", va, 0);
    tick;
    chk("idle_frame_done", fa, 0);
    chk("idle_busy", ba, 0);

    // Frame B: hand-computed table, backpressure pattern with random stalls
    for (int i = 0; i < N; i++) v[i] = 0;
    for (int i = 0; i < 10; i++) v[i] = tbl[i].in_v;
    for (int i = 0; i < N; i++) begin
      if (i < 10) sbq.push_back('{tbl[i].e_r1s0, tbl[i].e_r0s0, tbl[i].e_r1s1, i, 1'b0});
      else sbq.push_back('{0, 0, 0, i, (i == N-1)});
    end
    drive_frame(v);
    drain(1, 1000);
    chk("bp_frame_done", fa, 1);
    tick;

    // Frame C: second done_in at the 5th beat
    for (int i = 0; i < N; i++) v[i] = int'($urandom_range(0, 4000)) - 2000;
    push_model(v);
    drive_frame(v);
    run_until(N-4, 50);
    chk("ovr_index_at_pulse", ia, 4);
    for (int i = 0; i < N; i++) result_in[i*IW +: IW] = 18'h1FFFF;
    done_in = 1'b1;
    tick;
    done_in = 1'b0;
    chk("ovr_set", {oa, ob, oc}, 3'b111);
    done_in = 1'b1; clr_overrun = 1'b1;
    tick;
    done_in = 1'b0;
    chk("ovr_set_wins", {oa, ob, oc}, 3'b111);
    tick;
    clr_overrun = 1'b0;
    chk("ovr_cleared", {oa, ob, oc}, 0);
    drain(0, 100);
    chk("ovr_frame_done", fa, 1);
    tick;

    // Frame D: accepted right after the overrun frame, reset at beat 12
    for (int i = 0; i < N; i++) v[i] = i*37 - 400;
    push_model(v);
    drive_frame(v);
    chk("after_ovr_capture", {va, ia}, {1'b1, 5'd0});
    run_until(N-12, 50);
    chk("rst_mid_index", ia, 12);
    rst = 1'b1;
    sbq.delete();
    tick;
    rst = 1'b0;
    chk("rst_mid_valid", {va, vb, vc}, 0);
    chk("rst_mid_busy", {ba, bb, bc}, 0);
    chk("rst_mid_index0", ia, 0);

    // Frame E: new data after mid-frame reset
    for (int i = 0; i < N; i++) v[i] = 600 - i*45;
    push_model(v);
    drive_frame(v);
    chk("post_rst_capture", {va, ia}, {1'b1, 5'd0});
    drain(0, 100);
    chk("post_rst_frame_done", fa, 1);
    tick;
    chk("post_rst_idle", {ba, fa, oa}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
